// File: rtl/camera_pkg.sv
// Shared camera-pipeline definitions: controller state encodings, row indices
// and the default pixel width used by the readout and converter stages.
package camera_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic ROW0 = 1'b0;
    localparam logic ROW1 = 1'b1;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: registers the strobe and emits a one-cycle pulse in the
// cycle the input first goes high.
module edge_detect_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!reset_n) d_q <= 1'b0;
        else          d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/frame_capture.sv
// Two-row frame grabber behind RE_Control; streams the frame over valid/ready.
// Optional trailing checksum word: define FRAME_CAPTURE_CHECKSUM_EN.
module frame_capture
    import camera_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int COLS   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ADC,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic              Erase,
    input  logic [DATA_W-1:0] Pix_data,
    input  logic              Out_ready,
    output logic              Out_valid,
    output logic [DATA_W-1:0] Out_data,
    output logic              Out_last,
    output logic              Frame_done,
    output logic              Sync_err,
    output logic              Overrun
);

    localparam int NPIX = 2 * COLS;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    localparam int NWORDS = NPIX + 1;
`else
    localparam int NWORDS = NPIX;
`endif
    localparam int CW = $clog2(COLS + 1);
    localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int RW = $clog2(NWORDS);
    localparam logic [CW-1:0] COL_FULL = CW'(COLS);
    localparam logic [RW-1:0] LAST_IDX = RW'(NWORDS - 1);

    state_t            state, state_n;
    logic [CW-1:0]     col0, col1, col0_n, col1_n;
    logic [RW-1:0]     rd_idx, rd_idx_n;
    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] pix_buf [NPIX];
    logic              sample, row_ok, row_sel, row_full;
    logic              accept, clear, sync_set, ovr_set, done_n;
    logic              handshake, last_word;

    edge_detect_rise u_adc_edge (
        .clk     (Clk),
        .reset_n (Reset),
        .d       (ADC),
        .pulse   (sample)
    );

    // Exactly one NRE low picks a row; NRE_1 high means row 1 is selected.
    assign row_ok    = NRE_1 ^ NRE_2;
    assign row_sel   = NRE_1 ? ROW1 : ROW0;
    assign row_full  = (row_sel == ROW1) ? (col1 == COL_FULL) : (col0 == COL_FULL);
    assign wr_idx    = (row_sel == ROW1) ? IW'(COLS) + IW'(col1) : IW'(col0);
    assign Out_valid = (state == DRAIN);
    assign handshake = Out_valid && Out_ready;
    assign last_word = (rd_idx == LAST_IDX);
    assign Out_last  = Out_valid && last_word;

    always_comb begin
        state_n  = state;
        col0_n   = col0;
        col1_n   = col1;
        rd_idx_n = rd_idx;
        accept   = 1'b0;
        clear    = 1'b0;
        sync_set = 1'b0;
        ovr_set  = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE, CAPTURE: begin
                if (Erase) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end else if (sample) begin
                    if (!row_ok || row_full) begin
                        sync_set = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (row_sel == ROW1) col1_n = col1 + 1'b1;
                        else                 col0_n = col0 + 1'b1;
                        state_n = (col0_n == COL_FULL && col1_n == COL_FULL) ? DRAIN : CAPTURE;
                    end
                end
            end
            DRAIN: begin
                ovr_set = sample;
                if (handshake) begin
                    if (last_word) begin
                        state_n = IDLE;
                        clear   = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        rd_idx_n = rd_idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (clear) begin
            col0_n   = '0;
            col1_n   = '0;
            rd_idx_n = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            col0       <= '0;
            col1       <= '0;
            rd_idx     <= '0;
            Frame_done <= 1'b0;
            Sync_err   <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            col0       <= col0_n;
            col1       <= col1_n;
            rd_idx     <= rd_idx_n;
            Frame_done <= done_n;
            if (sync_set) Sync_err <= 1'b1;
            if (ovr_set)  Overrun  <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) pix_buf[wr_idx] <= Pix_data;
    end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
    logic [DATA_W-1:0] acc;

    always_ff @(posedge Clk) begin
        if (!Reset || clear) acc <= '0;
        else if (accept)     acc <= acc + Pix_data;
    end

    always_comb begin
        Out_data = '0;
        if (Out_valid) Out_data = last_word ? acc : pix_buf[IW'(rd_idx)];
    end
`else
    always_comb begin
        Out_data = '0;
        if (Out_valid) Out_data = pix_buf[IW'(rd_idx)];
    end
`endif

endmodule
